uart_rx: RTL and testbench

Serial receiver that sits directly downstream of the UART transmitter on the 40 kHz clock domain. It accepts an asynchronous 8N1 serial line (start bit, 8 data bits LSB-first, 1 stop bit) and recovers each byte by mid-bit sampling. It presents each received byte on a parallel bus with a one-cycle valid strobe and flags framing errors. In loopback it consumes the transmitter's `bit_out` directly.

---
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_rx.sv | 133 +++++++++++++
 tb/tb_uart_rx.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receiver-side bus of uart_rx: serial line in, recovered byte with valid/error strobes and busy out.
// master is the receiver itself, slave is the consumer that drives the line and reads the byte.
interface uart_rx_if;
  logic       rx_in;
  logic [7:0] dout;
  logic       dout_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rx_in,
    output dout,
    output dout_valid,
    output frame_err,
    output busy
  );

  modport slave (
    output rx_in,
    input  dout,
    input  dout_valid,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, mid-bit sampling, byte out 382 cycles after the first low sample, no backpressure (strobes only).
// Define UART_RX_MAJORITY_EN to take every sample as the 2-of-3 majority of the synchronized line history.
module uart_rx #(
  parameter int CLK_FREQ = 40000,
  parameter int UART_BPS = 1000
) (
  input logic      clk_40k,
  input logic      rst,
  uart_rx_if.master bus
);

  localparam int BIT_CNT  = CLK_FREQ / UART_BPS;
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int CNT_W    = $clog2(BIT_CNT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic [7:0]       dout_q, dout_nxt;
  logic             valid_q, valid_nxt;
  logic             ferr_q, ferr_nxt;
  logic             armed, armed_nxt;
  logic             rx_s1, rx_s2;
  logic             sample;

`ifdef UART_RX_MAJORITY_EN
  // Window is the current rx_s2 plus its two previous values, so sample edges match the plain build.
  logic [1:0] rx_hist_q;
  logic [2:0] rx_hist;
  assign rx_hist = {rx_hist_q, rx_s2};
  assign sample  = (rx_hist[0] & rx_hist[1]) | (rx_hist[0] & rx_hist[2]) | (rx_hist[1] & rx_hist[2]);

  always_ff @(posedge clk_40k) begin
    if (rst) rx_hist_q <= 2'b11;
    else     rx_hist_q <= rx_hist[1:0];
  end
`else
  assign sample = rx_s2;
`endif

  always_ff @(posedge clk_40k) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      rx_s1   <= bus.rx_in;
      rx_s2   <= rx_s1;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      shreg   <= shreg_nxt;
      dout_q  <= dout_nxt;
      valid_q <= valid_nxt;
      ferr_q  <= ferr_nxt;
      armed   <= armed_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    dout_nxt  = dout_q;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    armed_nxt = armed;
    case (state)
      IDLE: begin
        // armed keeps a line stuck low (after a framing error or reset) from looking like a start bit
        if (rx_s2) armed_nxt = 1'b1;
        if (armed && !rx_s2) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = sample ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          shreg_nxt = {sample, shreg[7:1]};
          cnt_nxt   = '0;
          if (idx == 3'd7) state_nxt = STOP;
          else             idx_nxt   = idx + 3'd1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          if (sample) begin
            dout_nxt  = shreg;
            valid_nxt = 1'b1;
          end else begin
            ferr_nxt  = 1'b1;
            armed_nxt = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives 8N1 frames cycle by cycle and checks strobes, data and timing.
module tb_uart_rx;
  logic clk_40k = 1'b0;
  logic rst     = 1'b1;

  uart_rx_if bus();

  uart_rx #(.CLK_FREQ(40000), .UART_BPS(1000)) dut (
    .clk_40k (clk_40k),
    .rst     (rst),
    .bus     (bus.master)
  );

  always #5 clk_40k = ~clk_40k;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vld_cnt = 0, err_cnt = 0, both_cnt = 0, rise_cnt = 0;
  int vld_cyc = 0, prev_vld_cyc = 0, err_cyc = 0, rise_cyc = 0, fall_cyc = 0;
  logic [7:0] vld_dat = 8'h00, prev_vld_dat = 8'h00;
  logic busy_d = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Edge monitor: cyc equals the number of the edge just taken.
  initial forever begin
    @(posedge clk_40k);
    cyc++;
    #1;
    if (bus.dout_valid === 1'b1) begin
      prev_vld_cyc = vld_cyc;
      prev_vld_dat = vld_dat;
      vld_cyc = cyc;
      vld_dat = bus.dout;
      vld_cnt++;
    end
    if (bus.frame_err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (bus.dout_valid === 1'b1 && bus.frame_err === 1'b1) both_cnt++;
    if (bus.busy === 1'b1 && busy_d !== 1'b1) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    if (bus.busy === 1'b0 && busy_d === 1'b1) fall_cyc = cyc;
    busy_d = bus.busy;
  end

  // Called at a negedge; t0 is the next edge, which samples the start bit.
  task automatic send_frame(input logic [7:0] data, input logic stop, input int glitch, output int t0);
    t0 = cyc + 1;
    for (int k = 0; k < 400; k++) begin
      logic b;
      if (k < 40)       b = 1'b0;
      else if (k < 360) b = data[(k - 40) / 40];
      else              b = stop;
      if (k == glitch) b = ~b;
      bus.rx_in = b;
      @(negedge clk_40k);
    end
  endtask

  task automatic idle(input int n);
    bus.rx_in = 1'b1;
    repeat (n) @(negedge clk_40k);
  endtask

  initial begin
    int t0, t1, v0, e0, r0;
    logic [7:0] glitch_exp;
    bus.rx_in = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk_40k);
    check("rst_dout", bus.dout, 8'h00);
    check("rst_valid", bus.dout_valid, 1'b0);
    check("rst_ferr", bus.frame_err, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    idle(10);

    v0 = vld_cnt; e0 = err_cnt;
    send_frame(8'hA5, 1'b1, -1, t0);
    idle(20);
    check("a5_vld_cnt", vld_cnt - v0, 1);
    check("a5_vld_cyc", vld_cyc, t0 + 382);
    check("a5_dout", bus.dout, 8'hA5);
    check("a5_err_cnt", err_cnt - e0, 0);
    check("a5_busy_rise", rise_cyc, t0 + 2);
    check("a5_busy_fall", fall_cyc, t0 + 382);

    v0 = vld_cnt;
    send_frame(8'h00, 1'b1, -1, t0);
    send_frame(8'hFF, 1'b1, -1, t1);
    idle(20);
    check("b2b_vld_cnt", vld_cnt - v0, 2);
    check("b2b_first_cyc", prev_vld_cyc, t0 + 382);
    check("b2b_spacing", vld_cyc - prev_vld_cyc, 400);
    check("b2b_first_dat", prev_vld_dat, 8'h00);
    check("b2b_second_dat", vld_dat, 8'hFF);

    v0 = vld_cnt; e0 = err_cnt;
    t0 = cyc + 1;
    bus.rx_in = 1'b0;
    repeat (5) @(negedge clk_40k);
    idle(60);
    check("glitch_start_vld", vld_cnt - v0, 0);
    check("glitch_start_err", err_cnt - e0, 0);
    check("glitch_start_rise", rise_cyc, t0 + 2);
    check("glitch_start_fall", fall_cyc, t0 + 22);
    check("glitch_start_dout", bus.dout, 8'hFF);

    v0 = vld_cnt; e0 = err_cnt; r0 = rise_cnt;
    send_frame(8'h3C, 1'b0, -1, t0);
    bus.rx_in = 1'b0;
    repeat (200) @(negedge clk_40k);
    check("ferr_cnt", err_cnt - e0, 1);
    check("ferr_cyc", err_cyc, t0 + 382);
    check("ferr_no_vld", vld_cnt - v0, 0);
    check("ferr_dout_kept", bus.dout, 8'hFF);
    check("ferr_no_restart", rise_cnt - r0, 1);
    idle(40);
    send_frame(8'h55, 1'b1, -1, t0);
    idle(20);
    check("after_ferr_dout", bus.dout, 8'h55);
    check("after_ferr_vld_cyc", vld_cyc, t0 + 382);

    v0 = vld_cnt; e0 = err_cnt;
    fork
      send_frame(8'hFF, 1'b1, -1, t0);
      begin
        repeat (200) @(negedge clk_40k);
        rst = 1'b1;
        @(negedge clk_40k);
        check("midrst_dout", bus.dout, 8'h00);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_valid", bus.dout_valid, 1'b0);
        rst = 1'b0;
      end
    join
    idle(40);
    check("midrst_no_vld", vld_cnt - v0, 0);
    check("midrst_no_err", err_cnt - e0, 0);
    send_frame(8'h81, 1'b1, -1, t0);
    idle(20);
    check("after_rst_dout", bus.dout, 8'h81);
    check("after_rst_vld_cyc", vld_cyc, t0 + 382);

`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'h00;
`else
    glitch_exp = 8'h08;
`endif
    v0 = vld_cnt;
    send_frame(8'h00, 1'b1, 180, t0);
    idle(20);
    check("bit3_glitch_vld", vld_cnt - v0, 1);
    check("bit3_glitch_dout", bus.dout, glitch_exp);

    check("vld_err_exclusive", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
